sub_serial_16: RTL and testbench
================================

Name: sub_serial_16

Overview:
- Multi-cycle two's-complement subtractor computing diff = a - b - b_in, one 4-bit slice per clock, LSB slice first.
- Each slice uses the team's carry-select structure:
  - two 4-bit ripple adds of a_slice + ~b_slice, one with carry-in 0 and one with carry-in 1;
  - a 2:1 mux on the registered inter-slice carry picks the result.
- Sits beside the combinational 16-bit carry-select adder as its subtract counterpart for area-constrained datapaths.
- Valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - b_in modulo 2^WIDTH.
- b_out  output  1  unsigned borrow out: 1 when a < b + b_in.
- ovf  output  1  signed overflow.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - state goes to IDLE;
  - diff, b_out, ovf and the slice counter are cleared to 0;
  - out_valid = 0;
  - in_ready = 0 while rst is high, 1 in the first cycle after rst deasserts.
- Reset mid-operation aborts the computation with no result produced.
- State machine:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1 at an edge:
    - register a and b;
    - carry register <= ~b_in;
    - slice counter <= 0;
    - go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge:
    - compute slice k = counter, as s0 = a_k + ~b_k + 0 and s1 = a_k + ~b_k + 1;
    - diff[4k+3:4k] <= carry ? s1 : s0;
    - carry <= carry ? c1 : c0;
    - counter increments.
    - On the edge processing slice NSLICE-1: set b_out <= ~final_carry, set ovf, go to DONE.
  - DONE: out_valid=1, in_ready=0. diff, b_out and ovf are held stable. When out_ready=1 at an edge, go to IDLE.
- Latency: operands accepted at edge T produce out_valid=1 in the cycle after edge T+NSLICE (4 cycles for WIDTH=16).
- Throughput: one result per NSLICE+2 cycles.
- Handshake rules:
  - in_valid while not in IDLE is ignored; operands are not captured.
  - in_valid and out_ready may both be high in DONE: the result is consumed, and new input is accepted only in the following IDLE cycle.
  - diff holds its previous value in IDLE and updates slice by slice during CALC. Consumers sample it only when out_valid=1.
- Overflow rule: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the final diff. b_in is included in the subtraction but not in the sign test.
- Wrap-around: diff is modulo 2^WIDTH; no exceptions are raised.

Optional Feature:
- Macro: SUB_SAT_EN.
- Defined: unsigned saturation.
  - When the final borrow is 1, diff is forced to 0 at the transition into DONE.
  - b_out still reports 1.
  - ovf is computed on the unsaturated result.
- Undefined: diff is always the modulo result and no saturation logic is present.

Test Plan:
- Basic subtract: reset, then a=0x1234, b=0x0234, b_in=0 -> out_valid exactly 4 cycles after accept; diff=0x1000, b_out=0, ovf=0.
- Borrow and wrap: a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0. With SUB_SAT_EN: diff=0x0000, b_out=1.
- Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, b_out=0. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, b_out=1.
- Borrow in and cross-slice carry: a=0x0010, b=0x000F, b_in=1 -> diff=0x0000, b_out=0. Also a=0x1000, b=0x0001, b_in=1 -> diff=0x0FFE.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff, b_out and ovf stable, in_ready=0, and a new in_valid is not captured. Raise out_ready -> IDLE next cycle, and the next operands are accepted.
- Reset mid-CALC: assert rst after 2 slice cycles -> next cycle out_valid=0, diff=0, b_out=0, ovf=0. in_ready=1 the cycle after rst drops; no stale result appears.

Source files
------------

// File: rtl/sub_serial_16.sv
// Multi-cycle subtractor: diff = a - b - b_in, one 4-bit carry-select slice per clock, LSB first.
// Define SUB_SAT_EN to clamp diff to zero on an unsigned borrow (unsigned saturation).
module sub_serial_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int BASE_W = CNT_W + 2;

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("sub_serial_16: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // 4-bit ripple add with carry out in bit 4.
    function automatic logic [4:0] ripple4(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       cin);
        logic [4:0] s;
        logic       c;
        s = '0;
        c = cin;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        s[4] = c;
        return s;
    endfunction

`ifdef SUB_SAT_EN
    function automatic logic [WIDTH-1:0] sat_unsigned(input logic [WIDTH-1:0] d,
                                                      input logic             borrow);
        return borrow ? '0 : d;
    endfunction
`endif

    state_t           r_state;
    logic             r_idle;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_b_out;
    logic             r_ovf;

    logic [BASE_W-1:0] w_base;
    logic [3:0]        w_a_sl;
    logic [3:0]        w_nb_sl;
    logic [4:0]        w_s0;
    logic [4:0]        w_s1;
    logic [3:0]        w_sum;
    logic              w_cout;
    logic [WIDTH-1:0]  w_diff_nx;
    logic              w_last;
    logic              w_ovf;

    // Carry-select slice: both carry-in cases are precomputed, the registered carry picks one.
    always_comb begin
        w_base    = {r_cnt, 2'b00};
        w_a_sl    = r_a[w_base +: 4];
        w_nb_sl   = ~r_b[w_base +: 4];
        w_s0      = ripple4(w_a_sl, w_nb_sl, 1'b0);
        w_s1      = ripple4(w_a_sl, w_nb_sl, 1'b1);
        w_sum     = r_carry ? w_s1[3:0] : w_s0[3:0];
        w_cout    = r_carry ? w_s1[4] : w_s0[4];
        w_diff_nx = r_diff;
        w_diff_nx[w_base +: 4] = w_sum;
        w_last    = (r_cnt == CNT_W'(NSLICE - 1));
        w_ovf     = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff_nx[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_b_out     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= ~b_in;
                        r_cnt   <= '0;
                        r_idle  <= 1'b0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_carry <= w_cout;
                    if (w_last) begin
                        // Carry out of a + ~b + ~b_in is the inverse of the unsigned borrow.
`ifdef SUB_SAT_EN
                        r_diff <= sat_unsigned(w_diff_nx, ~w_cout);
`else
                        r_diff <= w_diff_nx;
`endif
                        r_b_out     <= ~w_cout;
                        r_ovf       <= w_ovf;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_diff <= w_diff_nx;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_idle      <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Masked by rst so the block never advertises readiness while held in reset.
    assign in_ready  = r_idle & ~rst;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign b_out     = r_b_out;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sub_serial_16.sv
// Self-checking bench for sub_serial_16: directed, random, backpressure, back-to-back and reset scenarios.
module tb_sub_serial_16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        b_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    sub_serial_16 #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .b_in     (b_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .b_out    (b_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer subtraction; borrow is simply a negative result.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                  output logic [15:0] md, output logic mbo, output logic mov);
        int full;
        full = int'(ma) - int'(mb) - int'(mbin);
        md   = full[15:0];
        mbo  = (full < 0);
        mov  = (ma[15] != mb[15]) && (md[15] != ma[15]);
`ifdef SUB_SAT_EN
        if (mbo) md = '0;
`endif
    endfunction

    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic xbin,
                          output logic [15:0] d, output logic bo, output logic ov,
                          output int lat, output bit to);
        int w;
        w = 0; to = 1'b0; lat = 0; d = '0; bo = 1'b0; ov = 1'b0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        a = xa; b = xb; b_in = xbin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        d = diff; bo = b_out; ov = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h1357; b = 16'h0246;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 0/0", in_ready, out_valid);
        end
        n_checks++;
        if (diff !== 16'h0000 || b_out !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: diff=%h b_out=%b ovf=%b, required 0000/0/0", diff, b_out, ovf);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [6]   = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h0010, 16'h1000};
        logic [15:0] vb [6]   = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h000F, 16'h0001};
        logic        vbin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] vd [6]   = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0FFE};
        logic        vbo [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        vov [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] d, exp_d;
        logic        bo, ov;
        int          lat;
        bit          to;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vbin[i], d, bo, ov, lat, to);
            exp_d = vd[i];
`ifdef SUB_SAT_EN
            if (vbo[i]) exp_d = '0;
`endif
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL directed_%0d_timeout: handshake did not complete, required completion", i);
                continue;
            end
            if (d !== exp_d || bo !== vbo[i] || ov !== vov[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: diff=%h b_out=%b ovf=%b, required %h/%b/%b",
                         i, d, bo, ov, exp_d, vbo[i], vov[i]);
            end
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL directed_%0d_latency: %0d cycles, required 4", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rb, d, ed;
        logic        rbin, bo, ov, ebo, eov;
        int          lat;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 16'hFFFF;
            if (i % 8 == 2) ra = 16'h0000;
            model(ra, rb, rbin, ed, ebo, eov);
            run_op(ra, rb, rbin, d, bo, ov, lat, to);
            n_checks++;
            if (to || d !== ed || bo !== ebo || ov !== eov || lat !== 4) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h bin=%b got diff=%h b_out=%b ovf=%b lat=%0d to=%0d, required %h/%b/%b lat=4",
                         i, ra, rb, rbin, d, bo, ov, lat, to, ed, ebo, eov);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ed, d, nd;
        logic        ebo, eov, bo, ov, nbo, nov;
        int          w, lat;
        bit          to;
        model(16'hA5A5, 16'h5A5A, 1'b1, ed, ebo, eov);
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        a = 16'hA5A5; b = 16'h5A5A; b_in = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_start: out_valid=%b, required 1", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); b_in = 1'b0;
            out_ready = 1'b0;
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || b_out !== ebo || ovf !== eov) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: ov=%b ir=%b diff=%h b_out=%b ovf=%b, required 1/0/%h/%b/%b",
                         i, out_valid, in_ready, diff, b_out, ovf, ed, ebo, eov);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== ed) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b diff=%h, required 0/1/%h",
                     out_valid, in_ready, diff, ed);
        end
        model(16'h4000, 16'h0123, 1'b0, nd, nbo, nov);
        run_op(16'h4000, 16'h0123, 1'b0, d, bo, ov, lat, to);
        n_checks++;
        if (to || d !== nd || bo !== nbo || ov !== nov) begin
            n_fail++;
            $display("FAIL bp_next: diff=%h b_out=%b ovf=%b to=%0d, required %h/%b/%b",
                     d, bo, ov, to, nd, nbo, nov);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qd [$];
        logic        qbo [$];
        logic        qov [$];
        logic [15:0] ed;
        logic        ebo, eov;
        int          last_cyc, n_res;
        bit          acc;
        last_cyc = -1; n_res = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                n_checks++;
                if (qd.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: result %h with no accepted operands, required none", diff);
                end else begin
                    ed = qd.pop_front(); ebo = qbo.pop_front(); eov = qov.pop_front();
                    if (diff !== ed || b_out !== ebo || ovf !== eov) begin
                        n_fail++;
                        $display("FAIL b2b_data: diff=%h b_out=%b ovf=%b, required %h/%b/%b",
                                 diff, b_out, ovf, ed, ebo, eov);
                    end
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc !== 6) begin
                        n_fail++;
                        $display("FAIL b2b_gap: %0d cycles between results, required 6", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n_res++;
            end
            acc = in_ready && in_valid;
            if (acc) begin
                model(a, b, b_in, ed, ebo, eov);
                qd.push_back(ed); qbo.push_back(ebo); qov.push_back(eov);
            end
            tick();
            if (acc) begin
                a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid && qd.size() != 0) begin
                ed = qd.pop_front(); ebo = qbo.pop_front(); eov = qov.pop_front();
                n_checks++;
                if (diff !== ed || b_out !== ebo || ovf !== eov) begin
                    n_fail++;
                    $display("FAIL b2b_drain: diff=%h b_out=%b ovf=%b, required %h/%b/%b",
                             diff, b_out, ovf, ed, ebo, eov);
                end
                n_res++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (qd.size() != 0 || n_res < 6) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results with %0d outstanding, required >=6 and 0", n_res, qd.size());
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] d, ed;
        logic        bo, ov, ebo, eov;
        int          w, lat;
        bit          to;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        a = 16'hFFFF; b = 16'h1111; b_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hs: out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
        end
        n_checks++;
        if (diff !== 16'h0000 || b_out !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out: diff=%h b_out=%b ovf=%b, required 0000/0/0", diff, b_out, ovf);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: in_ready=%b, required 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_stale_%0d: out_valid=%b diff=%h, required out_valid 0", i, out_valid, diff);
            end
        end
        model(16'h0F0F, 16'h00F0, 1'b1, ed, ebo, eov);
        run_op(16'h0F0F, 16'h00F0, 1'b1, d, bo, ov, lat, to);
        n_checks++;
        if (to || d !== ed || bo !== ebo || ov !== eov || lat !== 4) begin
            n_fail++;
            $display("FAIL midrst_next: diff=%h b_out=%b ovf=%b lat=%0d to=%0d, required %h/%b/%b lat=4",
                     d, bo, ov, lat, to, ed, ebo, eov);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
